// File: rtl/armleocpu_pagefault_ad_unit.sv
// Registered page-permission checker with an optional hardware A/D writeback.
// Command encoding: 1 = EXECUTE, 2 = LOAD, 3 = STORE; other values skip the R/W/X check.
module armleocpu_pagefault_ad_unit #(
    parameter int unsigned HW_AD_UPDATE = 1,
    parameter int unsigned PTE_ADDR_W   = 34,
    parameter int unsigned CAUSE_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_cmd,
    input  logic [7:0]            req_accesstag,
    input  logic [PTE_ADDR_W-1:0] req_pte_addr,
    input  logic                  csr_satp_mode,
    input  logic [1:0]            csr_mcurrent_privilege,
    input  logic                  csr_mstatus_mprv,
    input  logic [1:0]            csr_mstatus_mpp,
    input  logic                  csr_mstatus_mxr,
    input  logic                  csr_mstatus_sum,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_pagefault,
    output logic [CAUSE_W-1:0]    resp_cause,
    output logic [7:0]            resp_accesstag,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [PTE_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_resp_valid,
    input  logic                  mem_resp_error
);

    localparam logic [3:0] CmdExecute = 4'd1;
    localparam logic [3:0] CmdLoad    = 4'd2;
    localparam logic [3:0] CmdStore   = 4'd3;

    localparam logic [1:0] PrivUser       = 2'd0;
    localparam logic [1:0] PrivSupervisor = 2'd1;
    localparam logic [1:0] PrivMachine    = 2'd3;

    localparam logic [CAUSE_W-1:0] CauseNone     = CAUSE_W'(0);
    localparam logic [CAUSE_W-1:0] CauseInvalid  = CAUSE_W'(1);
    localparam logic [CAUSE_W-1:0] CauseSupUser  = CAUSE_W'(2);
    localparam logic [CAUSE_W-1:0] CauseUserSup  = CAUSE_W'(3);
    localparam logic [CAUSE_W-1:0] CausePerm     = CAUSE_W'(4);
    localparam logic [CAUSE_W-1:0] CauseAClear   = CAUSE_W'(5);
    localparam logic [CAUSE_W-1:0] CauseDClear   = CAUSE_W'(6);
    localparam logic [CAUSE_W-1:0] CauseBusError = CAUSE_W'(7);

    localparam int unsigned TagV = 0;
    localparam int unsigned TagR = 1;
    localparam int unsigned TagW = 2;
    localparam int unsigned TagX = 3;
    localparam int unsigned TagU = 4;
    localparam int unsigned TagA = 6;
    localparam int unsigned TagD = 7;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMemReq,
        StMemWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [3:0]            cmd_q;
    logic [7:0]            tag_q;
    logic [PTE_ADDR_W-1:0] addr_q;
    logic                  satp_q;
    logic [1:0]            priv_q;
    logic                  mprv_q;
    logic [1:0]            mpp_q;
    logic                  mxr_q;
    logic                  sum_q;

    logic                  pagefault_q, pagefault_d;
    logic [CAUSE_W-1:0]    cause_q, cause_d;
    logic [7:0]            rtag_q, rtag_d;
    logic [7:0]            wdata_q, wdata_d;

    logic [1:0]            eff_priv;
    logic                  is_store;
    logic                  perm_bad;
    logic                  chk_fault;
    logic                  chk_update;
    logic [CAUSE_W-1:0]    chk_cause;
    logic [7:0]            chk_wdata;

    // Fault evaluation on the captured request; first matching rule wins.
    always_comb begin
        eff_priv   = (priv_q == PrivMachine && mprv_q) ? mpp_q : priv_q;
        is_store   = (cmd_q == CmdStore);
        perm_bad   = (is_store && !tag_q[TagW]) ||
                     (cmd_q == CmdLoad && !tag_q[TagR] && !(mxr_q && tag_q[TagX])) ||
                     (cmd_q == CmdExecute && !tag_q[TagX]);
        chk_wdata  = tag_q | 8'h40 | (is_store ? 8'h80 : 8'h00);
        chk_fault  = 1'b0;
        chk_update = 1'b0;
        chk_cause  = CauseNone;
        if (eff_priv == PrivMachine || !satp_q) begin
            chk_fault = 1'b0;
        end else if (!tag_q[TagV] || (!tag_q[TagR] && !tag_q[TagX])) begin
            chk_fault = 1'b1;
            chk_cause = CauseInvalid;
        end else if (eff_priv == PrivSupervisor && tag_q[TagU] && !sum_q) begin
            chk_fault = 1'b1;
            chk_cause = CauseSupUser;
        end else if (eff_priv == PrivUser && !tag_q[TagU]) begin
            chk_fault = 1'b1;
            chk_cause = CauseUserSup;
        end else if (perm_bad) begin
            chk_fault = 1'b1;
            chk_cause = CausePerm;
        end else if (!tag_q[TagA]) begin
            if (HW_AD_UPDATE != 0) begin
                chk_update = 1'b1;
            end else begin
                chk_fault = 1'b1;
                chk_cause = CauseAClear;
            end
        end else if (is_store && !tag_q[TagD]) begin
            if (HW_AD_UPDATE != 0) begin
                chk_update = 1'b1;
            end else begin
                chk_fault = 1'b1;
                chk_cause = CauseDClear;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pagefault_d = pagefault_q;
        cause_d     = cause_q;
        rtag_d      = rtag_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) state_d = StCheck;
            end
            StCheck: begin
                if (chk_fault) begin
                    state_d     = StResp;
                    pagefault_d = 1'b1;
                    cause_d     = chk_cause;
                    rtag_d      = tag_q;
                end else if (chk_update) begin
                    state_d = StMemReq;
                    wdata_d = chk_wdata;
                end else begin
                    state_d     = StResp;
                    pagefault_d = 1'b0;
                    cause_d     = CauseNone;
                    rtag_d      = tag_q;
                end
            end
            StMemReq: begin
                if (mem_ready) state_d = StMemWait;
            end
            StMemWait: begin
                if (mem_resp_valid) begin
                    state_d = StResp;
                    if (mem_resp_error) begin
                        pagefault_d = 1'b1;
                        cause_d     = CauseBusError;
                        rtag_d      = tag_q;
                    end else begin
                        pagefault_d = 1'b0;
                        cause_d     = CauseNone;
                        rtag_d      = wdata_q;
                    end
                end
            end
            StResp: begin
                if (resp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            pagefault_q <= 1'b0;
            cause_q     <= CauseNone;
            rtag_q      <= 8'h00;
            wdata_q     <= 8'h00;
            cmd_q       <= 4'h0;
            tag_q       <= 8'h00;
            addr_q      <= '0;
            satp_q      <= 1'b0;
            priv_q      <= 2'd0;
            mprv_q      <= 1'b0;
            mpp_q       <= 2'd0;
            mxr_q       <= 1'b0;
            sum_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pagefault_q <= pagefault_d;
            cause_q     <= cause_d;
            rtag_q      <= rtag_d;
            wdata_q     <= wdata_d;
            if (state_q == StIdle && req_valid) begin
                cmd_q  <= req_cmd;
                tag_q  <= req_accesstag;
                addr_q <= req_pte_addr;
                satp_q <= csr_satp_mode;
                priv_q <= csr_mcurrent_privilege;
                mprv_q <= csr_mstatus_mprv;
                mpp_q  <= csr_mstatus_mpp;
                mxr_q  <= csr_mstatus_mxr;
                sum_q  <= csr_mstatus_sum;
            end
        end
    end

    assign req_ready      = (state_q == StIdle);
    assign resp_valid     = (state_q == StResp);
    assign mem_valid      = (state_q == StMemReq);
    assign resp_pagefault = pagefault_q;
    assign resp_cause     = cause_q;
    assign resp_accesstag = rtag_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;

endmodule
